// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory slave with a four-phase req/ack handshake and
// programmable wait states. Define MEM_PRELOAD_EN to load a boot image on reset.
module mem_responder #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        err,
   output logic [15:0] txn_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

   state_t         state, state_nxt;
   logic [3:0]     wait_cnt;
   logic           we_q;
   logic [11:0]    addr_q;
   logic [31:0]    wdata_q;
   logic           access;
   logic           in_range;
   logic [AW-1:0]  idx;
   logic [31:0]    mem [DEPTH];

   assign in_range = ({20'd0, addr_q} < DEPTH);
   assign idx      = addr_q[AW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      access    = 1'b0;
      case (state)
         IDLE: if (req) state_nxt = BUSY;
         BUSY: begin
            if (wait_cnt == '0) begin
               access    = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK:  if (!req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request is captured once in IDLE; the initiator may change its inputs afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt  <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         ack       <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         txn_count <= '0;
      end else begin
         if (state == IDLE && req) begin
            we_q     <= we;
            addr_q   <= addr;
            wdata_q  <= wdata;
            wait_cnt <= 4'(WAIT_CYCLES);
         end else if (state == BUSY && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end

         if (access) begin
            ack       <= 1'b1;
            err       <= !in_range;
            txn_count <= txn_count + 16'd1;
            if (!in_range)  rdata <= '0;
            else if (!we_q) rdata <= mem[idx];
         end else if (state == ACK && !req) begin
            ack <= 1'b0;
            err <= 1'b0;
         end
      end
   end

`ifdef MEM_PRELOAD_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         mem[0] <= 32'd3;
         mem[1] <= 32'd4;
         mem[2] <= 32'h5000_0001;
      end else if (access && we_q && in_range) begin
         mem[idx] <= wdata_q;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (access && we_q && in_range) mem[idx] <= wdata_q;
   end
`endif

endmodule
